// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// AXI constants and the default boot address.
package ifu_fetch_pkg;

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_OUT  = 3'd3,
        S_WAIT = 3'd4
    } ifu_state_t;

    localparam logic [2:0]  AXI_SIZE_WORD    = 3'b010;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-issue, non-speculative. Fetches one word
// over an AXI4-lite-style read channel, hands it to the IDU, then waits for
// writeback to report the next PC.
// Optional macro YSYX_IFU_PERF_EN adds fetch / stall performance counters.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_pc_next,
    input  logic              i_pc_update,
    output logic [ADDR_W-1:0] o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    output logic [2:0]        o_arsize,
    input  logic [31:0]       i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready,
    output logic              o_post_valid,
    input  logic              i_post_ready,
    output logic [31:0]       o_inst,
    output logic [ADDR_W-1:0] o_pc,
`ifdef YSYX_IFU_PERF_EN
    output logic [31:0]       o_perf_fetch_cnt,
    output logic [31:0]       o_perf_stall_cnt,
`endif
    output logic              o_fetch_err
);

    ifu_state_t        state;
    logic [ADDR_W-1:0] pc;
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;

    assign o_arsize = AXI_SIZE_WORD;

    // Fetch FSM with all bus and IDU outputs registered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            pend         <= 1'b0;
            pend_pc      <= '0;
            o_arvalid    <= 1'b0;
            o_rready     <= 1'b0;
            o_post_valid <= 1'b0;
            o_inst       <= '0;
            o_pc         <= '0;
            o_fetch_err  <= 1'b0;
            o_araddr     <= '0;
        end else begin
            unique case (state)
                S_BOOT: begin
                    o_araddr  <= {pc[ADDR_W-1:2], 2'b00};
                    o_arvalid <= 1'b1;
                    state     <= S_AR;
                end
                S_AR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (i_rvalid) begin
                        o_inst       <= i_rdata;
                        o_pc         <= pc;
                        o_fetch_err  <= (i_rresp != RESP_OKAY);
                        o_rready     <= 1'b0;
                        o_post_valid <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_post_ready) begin
                        o_post_valid <= 1'b0;
                        // An update arriving in the handshake cycle is newer
                        // than any buffered one, so it takes priority.
                        if (i_pc_update) begin
                            pc        <= i_pc_next;
                            o_araddr  <= {i_pc_next[ADDR_W-1:2], 2'b00};
                            o_arvalid <= 1'b1;
                            pend      <= 1'b0;
                            state     <= S_AR;
                        end else if (pend) begin
                            pc        <= pend_pc;
                            o_araddr  <= {pend_pc[ADDR_W-1:2], 2'b00};
                            o_arvalid <= 1'b1;
                            pend      <= 1'b0;
                            state     <= S_AR;
                        end else begin
                            state     <= S_WAIT;
                        end
                    end else if (i_pc_update) begin
                        pend    <= 1'b1;
                        pend_pc <= i_pc_next;
                    end
                end
                S_WAIT: begin
                    if (i_pc_update) begin
                        pc        <= i_pc_next;
                        o_araddr  <= {i_pc_next[ADDR_W-1:2], 2'b00};
                        o_arvalid <= 1'b1;
                        state     <= S_AR;
                    end
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

`ifdef YSYX_IFU_PERF_EN
    generate
        if (1) begin : g_perf
            // Count completed R handshakes and cycles spent waiting on the bus.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    o_perf_fetch_cnt <= '0;
                    o_perf_stall_cnt <= '0;
                end else begin
                    if (state == S_R && i_rvalid)
                        o_perf_fetch_cnt <= o_perf_fetch_cnt + 32'd1;
                    if (state == S_AR || state == S_R)
                        o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
                end
            end
        end
    endgenerate
`endif

`ifndef SYNTHESIS
    // Writeback may only redirect once the current instruction is out.
    a_no_early_update: assert property (@(posedge clock) disable iff (!reset)
        !(i_pc_update && (state == S_BOOT || state == S_AR || state == S_R)))
        else $error("ifu_fetch: i_pc_update while a fetch is in flight");
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: stimulus pushes expected AR addresses and
// IDU transactions; a negedge monitor pops and compares on each handshake.
module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } post_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_pc_next = '0;
    logic        i_pc_update = 1'b0;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready = 1'b0;
    logic [2:0]  o_arsize;
    logic [31:0] i_rdata = '0;
    logic [1:0]  i_rresp = '0;
    logic        i_rvalid = 1'b0;
    logic        o_rready;
    logic        o_post_valid;
    logic        i_post_ready = 1'b0;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_fetch_err;
`ifdef YSYX_IFU_PERF_EN
    logic [31:0] o_perf_fetch_cnt;
    logic [31:0] o_perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int ar_cnt = 0;
    int r_cnt  = 0;
    logic [31:0] exp_ar[$];
    post_t       exp_post[$];

    ifu_fetch #(.ADDR_W(32), .RESET_PC(32'h3000_0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_pc_next    (i_pc_next),
        .i_pc_update  (i_pc_update),
        .o_araddr     (o_araddr),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .o_arsize     (o_arsize),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
`ifdef YSYX_IFU_PERF_EN
        .o_perf_fetch_cnt (o_perf_fetch_cnt),
        .o_perf_stall_cnt (o_perf_stall_cnt),
`endif
        .o_fetch_err  (o_fetch_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares every handshake against the scoreboard queues.
    always @(negedge clock) begin
        if (reset) begin
            if (o_arvalid && i_arready) begin
                ar_cnt++;
                if (exp_ar.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
                else chk("araddr", o_araddr, exp_ar.pop_front());
            end
            if (o_rready && i_rvalid) r_cnt++;
            if (o_post_valid && i_post_ready) begin
                if (exp_post.size() == 0) chk("post_unexpected", 32'd1, 32'd0);
                else begin
                    post_t e;
                    e = exp_post.pop_front();
                    chk("inst", o_inst, e.inst);
                    chk("pc", o_pc, e.pc);
                    chk("fetch_err", {31'd0, o_fetch_err}, {31'd0, e.err});
                end
            end
        end
    end

    // Slave: accept AR after ar_dly cycles (checking the request holds),
    // then return data after r_dly cycles.
    task automatic serve(input logic [31:0] addr, input logic [31:0] pc,
                         input int ar_dly, input int r_dly,
                         input logic [31:0] data, input logic [1:0] resp);
        int n;
        n = 0;
        while (!o_arvalid && n < 20) begin tick(); n++; end
        if (!o_arvalid) begin chk("arvalid_timeout", 32'd0, 32'd1); return; end
        exp_ar.push_back(addr);
        exp_post.push_back('{inst: data, pc: pc, err: (resp != 2'b00)});
        for (int i = 0; i < ar_dly; i++) begin
            tick();
            chk("ar_hold_valid", {31'd0, o_arvalid}, 32'd1);
            chk("ar_hold_addr", o_araddr, addr);
        end
        i_arready = 1'b1;
        tick();
        i_arready = 1'b0;
        chk("rready_after_ar", {31'd0, o_rready}, 32'd1);
        for (int i = 0; i < r_dly; i++) tick();
        i_rvalid = 1'b1; i_rdata = data; i_rresp = resp;
        tick();
        i_rvalid = 1'b0; i_rdata = '0; i_rresp = '0;
        chk("post_valid_after_r", {31'd0, o_post_valid}, 32'd1);
    endtask

    task automatic post_accept();
        int n;
        n = 0;
        while (!o_post_valid && n < 20) begin tick(); n++; end
        if (!o_post_valid) begin chk("post_timeout", 32'd0, 32'd1); return; end
        i_post_ready = 1'b1;
        tick();
        i_post_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_pc_update = 1'b1; i_pc_next = pc;
        tick();
        i_pc_update = 1'b0;
        chk("arvalid_after_update", {31'd0, o_arvalid}, 32'd1);
    endtask

    initial begin
        int ar0, r0;
        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_arvalid", {31'd0, o_arvalid}, 32'd0);
        chk("rst_rready", {31'd0, o_rready}, 32'd0);
        chk("rst_post_valid", {31'd0, o_post_valid}, 32'd0);
        chk("rst_inst", o_inst, 32'd0);
        chk("rst_araddr", o_araddr, 32'd0);
        chk("arsize", {29'd0, o_arsize}, 32'd2);
        reset = 1'b1;
        tick();
        chk("boot_arvalid", {31'd0, o_arvalid}, 32'd1);
        chk("boot_araddr", o_araddr, 32'h3000_0000);
        serve(32'h3000_0000, 32'h3000_0000, 0, 0, 32'h0000_0413, 2'b00);
        post_accept();

        // Slow slave, single handshake each
        tick();
        ar0 = ar_cnt; r0 = r_cnt;
        redirect(32'h3000_0004);
        serve(32'h3000_0004, 32'h3000_0004, 3, 2, 32'h1234_5678, 2'b00);
        post_accept();
        tick();
        chk("one_ar", ar_cnt - ar0, 32'd1);
        chk("one_r", r_cnt - r0, 32'd1);

        // Backpressure with a buffered redirect
        redirect(32'h3000_0008);
        serve(32'h3000_0008, 32'h3000_0008, 0, 0, 32'h1111_1111, 2'b00);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin i_pc_update = 1'b1; i_pc_next = 32'h3000_0100; end
            tick();
            i_pc_update = 1'b0;
            chk("bp_valid", {31'd0, o_post_valid}, 32'd1);
            chk("bp_inst", o_inst, 32'h1111_1111);
            chk("bp_pc", o_pc, 32'h3000_0008);
        end
        post_accept();
        chk("pend_arvalid", {31'd0, o_arvalid}, 32'd1);
        chk("pend_araddr", o_araddr, 32'h3000_0100);

        // Error response
        serve(32'h3000_0100, 32'h3000_0100, 1, 0, 32'hDEAD_BEEF, 2'b10);
        // Redirect coinciding with the post handshake, misaligned target
        i_pc_update = 1'b1; i_pc_next = 32'h3000_0203;
        post_accept();
        i_pc_update = 1'b0;
        chk("hs_redirect_araddr", o_araddr, 32'h3000_0200);
        serve(32'h3000_0200, 32'h3000_0203, 0, 1, 32'hCAFE_0001, 2'b00);
        post_accept();

        // Reset while waiting for read data
        tick();
        redirect(32'h3000_0300);
        exp_ar.push_back(32'h3000_0300);
        i_arready = 1'b1;
        tick();
        i_arready = 1'b0;
        chk("mid_rready", {31'd0, o_rready}, 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_arvalid", {31'd0, o_arvalid}, 32'd0);
        chk("mid_rst_rready", {31'd0, o_rready}, 32'd0);
        chk("mid_rst_post_valid", {31'd0, o_post_valid}, 32'd0);
        reset = 1'b1;
        tick();
        chk("refetch_araddr", o_araddr, 32'h3000_0000);
        serve(32'h3000_0000, 32'h3000_0000, 0, 0, 32'h0000_0513, 2'b00);
        post_accept();

`ifdef YSYX_IFU_PERF_EN
        reset = 1'b0;
        repeat (2) tick();
        chk("perf_rst_fetch", o_perf_fetch_cnt, 32'd0);
        reset = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k != 0) redirect(32'h3000_0010 + 32'(k) * 4);
            serve((k == 0) ? 32'h3000_0000 : 32'h3000_0010 + 32'(k) * 4,
                  (k == 0) ? 32'h3000_0000 : 32'h3000_0010 + 32'(k) * 4,
                  0, 0, 32'h0000_0013 + 32'(k), 2'b00);
            post_accept();
            tick();
        end
        chk("perf_fetch", o_perf_fetch_cnt, 32'd4);
        chk("perf_stall", o_perf_stall_cnt, 32'd8);
`endif

        repeat (2) tick();
        chk("ar_queue_empty", exp_ar.size(), 32'd0);
        chk("post_queue_empty", exp_post.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
